// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - serial program loader writing a framed image into main memory
// Optional checksum stage enabled by UART_PROG_LOADER_CHECKSUM_EN.
module uart_prog_loader #(
   parameter int          CLK_FREQ     = 100_000_000,
   parameter int          BAUD         = 115_200,
   parameter int          ADDR_W       = 18,
   parameter int          MAX_WORDS    = 262_144,
   parameter int          TIMEOUT_BITS = 64,
   parameter logic [31:0] MAGIC        = 32'h5AA5_C33C
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              prog_rx_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wstrb_o,
   output logic              sys_rst_n_o,
   output logic              prog_mode_o,
   output logic              err_o
);
   localparam int CPB       = CLK_FREQ / BAUD;
   localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
   localparam int BIT_CW    = $clog2(CPB);
   localparam int TO_W      = $clog2(TO_CYCLES + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      F_IDLE, F_MAGIC, F_LEN, F_DATA,
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      F_CSUM,
`endif
      F_DONE
   } f_state_t;

   rx_state_t         rx_state;
   logic              rx_m, rx_s, rx_p;
   logic [BIT_CW-1:0] bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        rx_shift;
   logic              byte_vld, frame_err;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         rx_p      <= 1'b1;
         rx_state  <= RX_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         rx_shift  <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_m      <= prog_rx_i;
         rx_s      <= rx_m;
         rx_p      <= rx_s;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: if (rx_p && !rx_s) begin
               rx_state <= RX_START;
               bit_cnt  <= '0;
            end
            RX_START: if (bit_cnt == BIT_CW'(CPB/2 - 1)) begin
               bit_cnt  <= '0;
               bit_idx  <= '0;
               rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else bit_cnt <= bit_cnt + 1'b1;
            RX_DATA: if (bit_cnt == BIT_CW'(CPB - 1)) begin
               bit_cnt  <= '0;
               rx_shift <= {rx_s, rx_shift[7:1]};
               bit_idx  <= bit_idx + 1'b1;
               if (bit_idx == 3'd7) rx_state <= RX_STOP;
            end else bit_cnt <= bit_cnt + 1'b1;
            RX_STOP: if (bit_cnt == BIT_CW'(CPB - 1)) begin
               bit_cnt   <= '0;
               rx_state  <= RX_IDLE;
               byte_vld  <= rx_s;
               frame_err <= !rx_s;
            end else bit_cnt <= bit_cnt + 1'b1;
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   f_state_t          state;
   logic [31:0]       window, word;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] addr, last_addr;
   logic [TO_W-1:0]   to_cnt;
   logic [31:0]       win_next, word_next;
   logic              in_frame;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
   logic [31:0]       sum;
`endif

   assign win_next  = {window[23:0], rx_shift};
   assign word_next = {rx_shift, word[31:8]};
   assign in_frame  = (state == F_LEN) || (state == F_DATA)
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                      || (state == F_CSUM)
`endif
                      ;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state       <= F_IDLE;
         window      <= '0;
         word        <= '0;
         byte_idx    <= '0;
         addr        <= '0;
         last_addr   <= '0;
         to_cnt      <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wstrb_o <= '0;
         sys_rst_n_o <= 1'b1;
         prog_mode_o <= 1'b0;
         err_o       <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
         sum         <= '0;
`endif
      end else begin
         mem_we_o    <= 1'b0;
         mem_wstrb_o <= 4'h0;
         if (frame_err) err_o <= 1'b1;
         case (state)
            F_IDLE, F_MAGIC: if (byte_vld) begin
               if (win_next == MAGIC) begin
                  state       <= F_LEN;
                  window      <= '0;
                  byte_idx    <= '0;
                  to_cnt      <= '0;
                  sys_rst_n_o <= 1'b0;
                  prog_mode_o <= 1'b1;
                  err_o       <= 1'b0;
               end else begin
                  window <= win_next;
                  state  <= F_MAGIC;
               end
            end
            F_LEN: if (byte_vld) begin
               word     <= word_next;
               byte_idx <= byte_idx + 1'b1;
               if (byte_idx == 2'd3) begin
                  addr      <= '0;
                  last_addr <= ADDR_W'(word_next - 32'd1);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                  sum       <= '0;
                  if (word_next == 32'd0) state <= F_CSUM;
`else
                  if (word_next == 32'd0) state <= F_DONE;
`endif
                  else if (word_next > 32'(MAX_WORDS)) begin
                     err_o       <= 1'b1;
                     state       <= F_IDLE;
                     sys_rst_n_o <= 1'b1;
                     prog_mode_o <= 1'b0;
                  end else state <= F_DATA;
               end
            end
            F_DATA: if (byte_vld) begin
               word     <= word_next;
               byte_idx <= byte_idx + 1'b1;
               if (byte_idx == 2'd3) begin
                  mem_we_o    <= 1'b1;
                  mem_wstrb_o <= 4'hF;
                  mem_addr_o  <= addr;
                  mem_wdata_o <= word_next;
                  addr        <= addr + 1'b1;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                  sum         <= sum + word_next;
                  if (addr == last_addr) state <= F_CSUM;
`else
                  if (addr == last_addr) state <= F_DONE;
`endif
               end
            end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            // A bad checksum leaves the core held in reset until a good frame arrives.
            F_CSUM: if (byte_vld) begin
               word     <= word_next;
               byte_idx <= byte_idx + 1'b1;
               if (byte_idx == 2'd3) begin
                  if (word_next == sum) state <= F_DONE;
                  else begin
                     err_o       <= 1'b1;
                     state       <= F_IDLE;
                     prog_mode_o <= 1'b0;
                  end
               end
            end
`endif
            F_DONE: begin
               sys_rst_n_o <= 1'b1;
               prog_mode_o <= 1'b0;
               state       <= F_IDLE;
            end
            default: state <= F_IDLE;
         endcase
         // Inter-byte watchdog; only reachable when no byte arrived this cycle.
         if (in_frame) begin
            if (byte_vld) to_cnt <= '0;
            else if (to_cnt == TO_W'(TO_CYCLES - 1)) begin
               to_cnt      <= '0;
               err_o       <= 1'b1;
               state       <= F_IDLE;
               sys_rst_n_o <= 1'b1;
               prog_mode_o <= 1'b0;
            end else to_cnt <= to_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
   localparam int ADDR_W = 18;
   localparam int CPB    = 16;

   logic              clk_i = 1'b0;
   logic              rst_n = 1'b0;
   logic              prog_rx_i = 1'b1;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [3:0]        mem_wstrb_o;
   logic              sys_rst_n_o, prog_mode_o, err_o;

   int errors = 0;
   int checks = 0;

   int                wr_total = 0;
   logic [ADDR_W-1:0] log_addr [16];
   logic [31:0]       log_data [16];
   logic [3:0]        log_strb [16];

   uart_prog_loader #(.CLK_FREQ(160), .BAUD(10), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .rst_n(rst_n), .prog_rx_i(prog_rx_i),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .sys_rst_n_o(sys_rst_n_o),
      .prog_mode_o(prog_mode_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // Every high cycle of mem_we_o is logged, so a stretched pulse shows as extra writes.
   always @(negedge clk_i) begin
      if (mem_we_o) begin
         log_addr[wr_total % 16] = mem_addr_o;
         log_data[wr_total % 16] = mem_wdata_o;
         log_strb[wr_total % 16] = mem_wstrb_o;
         wr_total = wr_total + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      prog_rx_i = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         prog_rx_i = b[i];
         wait_cycles(CPB);
      end
      prog_rx_i = stop;
      wait_cycles(CPB);
      prog_rx_i = 1'b1;
      if (!stop) wait_cycles(CPB);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic send_magic;
      send_byte(8'h5A, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'hC3, 1'b1);
      send_byte(8'h3C, 1'b1);
   endtask

   task automatic do_reset;
      @(negedge clk_i);
      rst_n = 1'b0;
      prog_rx_i = 1'b1;
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_reset;
      wait_cycles(3);
      rst_n = 1'b1;
      @(negedge clk_i);
      chk("reset_we", {31'd0, mem_we_o}, 32'd0);
      chk("reset_addr", 32'(mem_addr_o), 32'd0);
      chk("reset_wdata", mem_wdata_o, 32'd0);
      chk("reset_wstrb", {28'd0, mem_wstrb_o}, 32'd0);
      chk("reset_sys_rst_n", {31'd0, sys_rst_n_o}, 32'd1);
      chk("reset_prog_mode", {31'd0, prog_mode_o}, 32'd0);
      chk("reset_err", {31'd0, err_o}, 32'd0);
   endtask

   task automatic test_basic_load;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      chk("basic_sys_rst_low", {31'd0, sys_rst_n_o}, 32'd0);
      chk("basic_prog_mode", {31'd0, prog_mode_o}, 32'd1);
      send_word(32'd2);
      send_word(32'hDEADBEEF);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      send_word(32'h00000001);
      send_byte(8'hF0, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1);
      chk("basic_hold_before_last", {31'd0, sys_rst_n_o}, 32'd0);
      send_byte(8'hDE, 1'b1);
`else
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      chk("basic_hold_before_last", {31'd0, sys_rst_n_o}, 32'd0);
      send_byte(8'h00, 1'b1);
`endif
      chk("basic_sys_rst_release", {31'd0, sys_rst_n_o}, 32'd1);
      chk("basic_prog_mode_off", {31'd0, prog_mode_o}, 32'd0);
      chk("basic_err", {31'd0, err_o}, 32'd0);
      chk("basic_nwrites", 32'(wr_total - base), 32'd2);
      chk("basic_addr0", 32'(log_addr[base % 16]), 32'd0);
      chk("basic_data0", log_data[base % 16], 32'hDEADBEEF);
      chk("basic_strb0", {28'd0, log_strb[base % 16]}, 32'hF);
      chk("basic_addr1", 32'(log_addr[(base + 1) % 16]), 32'd1);
      chk("basic_data1", log_data[(base + 1) % 16], 32'h00000001);
      chk("basic_strb1", {28'd0, log_strb[(base + 1) % 16]}, 32'hF);
   endtask

   task automatic test_preamble_search;
      do_reset();
      send_byte(8'h5A, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'hC3, 1'b1);
      chk("preamble_not_yet", {31'd0, sys_rst_n_o}, 32'd1);
      send_byte(8'h3C, 1'b1);
      chk("preamble_detect", {31'd0, sys_rst_n_o}, 32'd0);
   endtask

   task automatic test_reset_abort;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      send_word(32'd1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      do_reset();
      chk("abort_sys_rst_n", {31'd0, sys_rst_n_o}, 32'd1);
      chk("abort_prog_mode", {31'd0, prog_mode_o}, 32'd0);
      send_byte(8'h44, 1'b1);
      wait_cycles(4);
      chk("abort_no_write", 32'(wr_total - base), 32'd0);
   endtask

   task automatic test_framing_error;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      send_word(32'd1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      chk("ferr_err", {31'd0, err_o}, 32'd1);
      chk("ferr_still_held", {31'd0, sys_rst_n_o}, 32'd0);
      wait_cycles(1100);
      chk("ferr_timeout_release", {31'd0, sys_rst_n_o}, 32'd1);
      chk("ferr_prog_mode", {31'd0, prog_mode_o}, 32'd0);
      chk("ferr_no_write", 32'(wr_total - base), 32'd0);
   endtask

   task automatic test_oversize;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      send_word(32'd262_145);
      chk("oversize_err", {31'd0, err_o}, 32'd1);
      chk("oversize_release", {31'd0, sys_rst_n_o}, 32'd1);
      chk("oversize_no_write", 32'(wr_total - base), 32'd0);
   endtask

   task automatic test_max_len_accepted;
      do_reset();
      send_magic();
      send_word(32'd262_144);
      chk("maxlen_no_err", {31'd0, err_o}, 32'd0);
      chk("maxlen_held", {31'd0, sys_rst_n_o}, 32'd0);
   endtask

   task automatic test_timeout;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      send_word(32'd1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      wait_cycles(1000);
      chk("timeout_not_early", {31'd0, sys_rst_n_o}, 32'd0);
      wait_cycles(40);
      chk("timeout_err", {31'd0, err_o}, 32'd1);
      chk("timeout_release", {31'd0, sys_rst_n_o}, 32'd1);
      chk("timeout_no_write", 32'(wr_total - base), 32'd0);
   endtask

   task automatic test_zero_len;
      int base;
      do_reset();
      base = wr_total;
      send_magic();
      send_word(32'd0);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      send_word(32'd0);
`endif
      chk("zero_release", {31'd0, sys_rst_n_o}, 32'd1);
      chk("zero_err", {31'd0, err_o}, 32'd0);
      chk("zero_no_write", 32'(wr_total - base), 32'd0);
   endtask

`ifdef UART_PROG_LOADER_CHECKSUM_EN
   task automatic test_checksum_mismatch;
      do_reset();
      send_magic();
      send_word(32'd1);
      send_word(32'd5);
      send_word(32'd6);
      chk("csum_bad_err", {31'd0, err_o}, 32'd1);
      wait_cycles(1200);
      chk("csum_bad_held", {31'd0, sys_rst_n_o}, 32'd0);
      send_magic();
      send_word(32'd1);
      send_word(32'd7);
      send_word(32'd7);
      chk("csum_good_err", {31'd0, err_o}, 32'd0);
      chk("csum_good_release", {31'd0, sys_rst_n_o}, 32'd1);
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_preamble_search();
      test_reset_abort();
      test_framing_error();
      test_oversize();
      test_max_len_accepted();
      test_timeout();
      test_zero_len();
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      test_checksum_mismatch();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that sits upstream of main memory. It receives a framed program image on the programming RX pin, writes it word by word into main memory through a single-cycle write port, and holds the processor in reset for the whole transfer. Its `mem_*` outputs drive the RAM write port directly. `sys_rst_n_o` is ANDed into the core reset alongside the board reset.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: serial bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, must be ≥ 8.
- `ADDR_W`, default 18: word-address width.
- `MAX_WORDS`, default 262_144: largest accepted image, in words.
- `TIMEOUT_BITS`, default 64: idle bit-times allowed between bytes inside a frame.
- `MAGIC`, default 32'h5AA5_C33C: frame preamble, sent MSB byte first.

Ports (reset rst_n is synchronous and active-low; clock is clk_i):
- `clk_i` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `prog_rx_i` in 1: asynchronous serial input, 8N1, idle high.
- `mem_we_o` out 1: one-cycle write strobe.
- `mem_addr_o` out ADDR_W: word address.
- `mem_wdata_o` out 32: write data.
- `mem_wstrb_o` out 4: 4'hF while `mem_we_o` is high, otherwise 0.
- `sys_rst_n_o` out 1: core reset request, low while loading.
- `prog_mode_o` out 1: LED, high while in a frame.
- `err_o` out 1: sticky error flag.

## Operation
- **RX front end.**
  - 2-flop synchronizer on `prog_rx_i`.
  - A falling edge in RX_IDLE starts a half-bit count. The start bit is rechecked at `CLKS_PER_BIT/2`; if it reads 1, this is a glitch and the receiver returns to idle.
  - The 8 data bits are sampled LSB first, each `CLKS_PER_BIT` cycles apart.
  - At the stop-bit sample: stop bit = 1 produces a one-cycle `byte_vld`. Stop bit = 0 is a framing error: the byte is dropped and `err_o` is set.
- **Frame FSM states:** IDLE, MAGIC, LEN, DATA, CSUM (macro only), DONE.
  - **IDLE / MAGIC:** bytes are shifted into a 32-bit window. When the window equals `MAGIC`:
    - go to LEN;
    - `sys_rst_n_o` goes 0 and `prog_mode_o` goes 1;
    - `err_o` is cleared.
  - **LEN:** 4 bytes, little-endian, form N (word count).
    - N = 0: go to DONE.
    - N > MAX_WORDS: set `err_o` and go to IDLE.
    - Otherwise: go to DATA with the address counter at 0.
  - **DATA:** 4 bytes, little-endian, form one word. On the 4th byte, `mem_we_o` pulses with the current address, then the address increments. After word N the FSM goes to CSUM, or to DONE when the macro is absent.
  - **DONE:** one cycle. `sys_rst_n_o` returns to 1, `prog_mode_o` returns to 0, then the FSM goes to IDLE.
- **Timeout.** In LEN, DATA or CSUM, a counter reloads on every `byte_vld`. After `TIMEOUT_BITS*CLKS_PER_BIT` cycles with no byte: set `err_o`, go to IDLE, release `sys_rst_n_o`. Words already written stay in memory.
- **Magic inside a frame.** Not recognised; the bytes are treated as payload.
- **Address width.** The address counter is ADDR_W wide. Because `MAX_WORDS` ≤ 2^ADDR_W it never wraps within an accepted frame.

## Timing
- Reset values:
  - `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_wstrb_o`=0;
  - `sys_rst_n_o`=1, `prog_mode_o`=0, `err_o`=0;
  - FSM in IDLE, RX in idle.
- `byte_vld` fires 1 cycle after the stop-bit mid-sample.
- `mem_we_o` is registered and high for exactly 1 cycle, 1 cycle after the `byte_vld` of the word's 4th byte. Address and data are valid in the same cycle.
- `sys_rst_n_o` falls 1 cycle after the last magic byte's `byte_vld`. It rises 1 cycle after the DONE/error transition.
- Asserting `rst_n` mid-frame aborts immediately: all state returns to reset values, with no partial write.
- Writes never back-pressure: the memory must accept one write per cycle. Consecutive writes are at least 4 byte-times apart.

## Configuration
- `UART_PROG_LOADER_CHECKSUM_EN` defined:
  - after the last data word, state CSUM receives a 4-byte little-endian word C;
  - if C equals the sum of all data words mod 2^32, go to DONE;
  - otherwise set `err_o` and keep `sys_rst_n_o` = 0 until the next valid frame or `rst_n`.
  - With N = 0, the expected checksum is 0.
- `UART_PROG_LOADER_CHECKSUM_EN` undefined:
  - no CSUM state and no checksum accumulator;
  - DATA goes directly to DONE.

## Test plan
All scenarios use `CLK_FREQ`=160, `BAUD`=10, giving 16 clk/bit.
- **Basic load.** Send magic, N=2, words 0xDEADBEEF and 0x00000001 (plus checksum 0xDEADBEF0 with the macro).
  - Required: two `mem_we_o` pulses at addresses 0 and 1 with those values and `mem_wstrb_o`=F;
  - `sys_rst_n_o` low from magic until 1 cycle after the last byte; `err_o`=0.
- **Preamble search.** Send 0x5A,0x5A,0xA5,0xC3,0x3C.
  - Required: frame detected (window sliding), `sys_rst_n_o` falls after 0x3C.
- **Framing error.** Send a byte with stop bit 0 during DATA.
  - Required: `err_o`=1, no write for that byte, then timeout returns to IDLE and `sys_rst_n_o`=1.
- **Oversize length.** N = MAX_WORDS+1.
  - Required: `err_o`=1, zero writes, `sys_rst_n_o`=1 within 2 cycles.
- **Timeout.** Stall 64 bit-times after 2 data bytes.
  - Required: `err_o`=1, IDLE, no partial write.
- **Checksum mismatch (macro only).** Send a wrong checksum.
  - Required: `err_o`=1 and `sys_rst_n_o` stays 0;
  - a following valid frame clears `err_o` and releases `sys_rst_n_o`.
